// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential PC generation, imem valid/ready requests and an in-order
// fetch queue feeding the decoder. Define IFU_BYPASS_EN to present a response combinationally
// when the queue is empty.
module ifu_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  // Must be a power of 2 and at least 2.
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_load,
  output logic            imem_req_vld,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_rdy,
  input  logic            imem_rsp_vld,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_vld,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_tag,
  input  logic            instr_rdy
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FQ_DEPTH);

  typedef enum logic [0:0] {StReset, StFetch} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   disc_q, disc_d;

  logic [XLEN-1:0] fifo_pc_q   [FQ_DEPTH];
  logic [31:0]     fifo_data_q [FQ_DEPTH];
  logic [PW-1:0]   fifo_rd_q, fifo_rd_d;
  logic [PW-1:0]   fifo_wr_q, fifo_wr_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;

  // PCs of requests still awaiting a response, including ones that will be discarded.
  logic [XLEN-1:0] tag_q [FQ_DEPTH];
  logic [PW-1:0]   tag_rd_q, tag_rd_d;
  logic [PW-1:0]   tag_wr_q, tag_wr_d;

  logic fifo_empty;
  logic credit_ok;
  logic req_fire;
  logic rsp_keep;
  logic byp_sel;
  logic push;
  logic pop;
  logic unused_pc_bits;

  assign unused_pc_bits = ^pc_in[1:0];

  assign fifo_empty = (fifo_cnt_q == '0);
  assign credit_ok  = (({1'b0, out_q} + {1'b0, fifo_cnt_q}) < DEPTH_C);
  assign req_fire   = imem_req_vld & imem_req_rdy;
  // A response survives only when no redirect lands this cycle and nothing is pending discard.
  assign rsp_keep   = imem_rsp_vld & ~pc_load & (disc_q == '0);

`ifdef IFU_BYPASS_EN
  assign byp_sel = fifo_empty & rsp_keep;
`else
  assign byp_sel = 1'b0;
`endif

  // Decoder side
  always_comb begin
    instr_vld = (~fifo_empty & ~pc_load) | byp_sel;
    if (byp_sel) begin
      instr     = imem_rsp_data;
      instr_tag = tag_q[tag_rd_q];
    end else begin
      instr     = fifo_data_q[fifo_rd_q];
      instr_tag = fifo_pc_q[fifo_rd_q];
    end
  end

  assign pop  = instr_vld & instr_rdy & ~fifo_empty;
  assign push = rsp_keep & ~(byp_sel & instr_rdy);

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // FSM: outputs
  always_comb begin
    imem_req_vld = 1'b0;
    unique case (state_q)
      StReset: imem_req_vld = 1'b0;
      StFetch: imem_req_vld = ~pc_load & credit_ok;
      default: imem_req_vld = 1'b0;
    endcase
    imem_req_addr = fetch_pc_q;
  end

  // Datapath next state
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q + CW'(req_fire) - CW'(imem_rsp_vld);
    disc_d     = disc_q;
    if (pc_load) begin
      fetch_pc_d = {pc_in[XLEN-1:2], 2'b00};
      disc_d     = out_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (imem_rsp_vld && (disc_q != '0)) begin
        disc_d = disc_q - CW'(1);
      end
    end

    tag_wr_d = req_fire ? tag_wr_q + PW'(1) : tag_wr_q;
    tag_rd_d = imem_rsp_vld ? tag_rd_q + PW'(1) : tag_rd_q;

    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (pc_load) begin
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      fifo_cnt_d = '0;
    end else begin
      if (push) begin
        fifo_wr_d = fifo_wr_q + PW'(1);
      end
      if (pop) begin
        fifo_rd_d = fifo_rd_q + PW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_data_q[i] <= '0;
        tag_q[i]       <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      if (push) begin
        fifo_pc_q[fifo_wr_q]   <= tag_q[tag_rd_q];
        fifo_data_q[fifo_wr_q] <= imem_rsp_data;
      end
      if (req_fire) begin
        tag_q[tag_wr_q] <= fetch_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed steps then randomized traffic, checked against a stream model in
// which requests and deliveries are both consecutive words starting at the latest redirect target.
module tb_ifu_fetch;

  localparam int unsigned FQ_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_load = 1'b0;
  logic        imem_req_vld;
  logic [31:0] imem_req_addr;
  logic        imem_req_rdy = 1'b0;
  logic        imem_rsp_vld = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_vld;
  logic [31:0] instr;
  logic [31:0] instr_tag;
  logic        instr_rdy = 1'b0;

  ifu_fetch #(
    .XLEN     (32),
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .pc_in         (pc_in),
    .pc_load       (pc_load),
    .imem_req_vld  (imem_req_vld),
    .imem_req_addr (imem_req_addr),
    .imem_req_rdy  (imem_req_rdy),
    .imem_rsp_vld  (imem_rsp_vld),
    .imem_rsp_data (imem_rsp_data),
    .instr_vld     (instr_vld),
    .instr         (instr),
    .instr_tag     (instr_tag),
    .instr_rdy     (instr_rdy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          last_due = -1;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] exp_req_pc;
  logic [31:0] exp_dec_pc;
  int          n_deliv = 0;
  int          n_req = 0;
  logic [31:0] last_req_addr = '0;
  bit          fresh = 1'b0;
  logic [31:0] first_tag = '1;
  logic        s_req_vld;
  logic [31:0] s_req_addr;
  logic        s_instr_vld;
  logic [31:0] s_instr;
  logic [31:0] s_tag;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond);
    chk(tag, cond ? 32'd1 : 32'd0, 32'd1);
  endtask

  // One clock cycle; entered just after a rising edge, returns 1 time unit after the next one.
  task automatic cycle(input bit load, input logic [31:0] tgt, input bit rrdy, input bit irdy);
    int d;
    pc_load      = load;
    pc_in        = tgt;
    imem_req_rdy = rrdy;
    instr_rdy    = irdy;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = mem_word(mq_addr[0]);
    end else begin
      imem_rsp_vld  = 1'b0;
      imem_rsp_data = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    s_req_vld   = imem_req_vld;
    s_req_addr  = imem_req_addr;
    s_instr_vld = instr_vld;
    s_instr     = instr;
    s_tag       = instr_tag;
    if (load) begin
      chk("load_blocks_instr_vld", {31'b0, s_instr_vld}, 32'd0);
      chk("load_blocks_req_vld", {31'b0, s_req_vld}, 32'd0);
    end
    if (s_instr_vld && irdy) begin
      chk("deliver_tag", s_tag, exp_dec_pc);
      chk("deliver_instr", s_instr, mem_word(exp_dec_pc));
      exp_dec_pc = exp_dec_pc + 32'd4;
      n_deliv++;
      if (fresh) begin
        first_tag = s_tag;
        fresh     = 1'b0;
      end
    end
    if (s_req_vld && rrdy) begin
      chk("req_addr", s_req_addr, exp_req_pc);
      exp_req_pc    = exp_req_pc + 32'd4;
      last_req_addr = s_req_addr;
      n_req++;
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq_addr.push_back(s_req_addr);
      mq_due.push_back(d);
      chk_true("credit_limit", mq_addr.size() <= FQ_DEPTH);
    end
    @(posedge clk);
    if (imem_rsp_vld) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (load) begin
      exp_req_pc = tgt & ~32'd3;
      exp_dec_pc = tgt & ~32'd3;
      fresh      = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn         = 1'b0;
    pc_load      = 1'b0;
    imem_req_rdy = 1'b0;
    imem_rsp_vld = 1'b0;
    instr_rdy    = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    exp_req_pc = RESET_PC;
    exp_dec_pc = RESET_PC;
    fresh      = 1'b0;
    @(negedge clk);
    chk("rst_req_vld", {31'b0, imem_req_vld}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_instr_vld", {31'b0, instr_vld}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_tag", instr_tag, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn     = 1'b1;
    cyc      = 0;
    last_due = -1;
  endtask

  task automatic drain(input logic [31:0] tgt);
    cycle(1'b1, tgt, 1'b0, 1'b1);
    repeat (5) cycle(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int          d0;
    int          r0;
    bit          got;
    logic [31:0] cap;
    bit          ld;
    logic [31:0] t;

    // Reset release and streaming
    do_reset();
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    chk("first_cycle_idle", {31'b0, s_req_vld}, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    chk("second_cycle_req", {31'b0, s_req_vld}, 32'd1);
    chk("second_cycle_addr", s_req_addr, RESET_PC);
    repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    d0 = n_deliv;
    repeat (9) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    chk_true("throughput", (n_deliv - d0) >= (BYP ? 8 : 5));

    // Decoder stall: credit caps outstanding + buffered
    do_reset();
    r0 = n_req;
    repeat (10) cycle(1'b0, 32'd0, 1'b1, 1'b0);
    chk("stall_req_count", n_req - r0, 32'd2);
    chk("stall_req_vld_low", {31'b0, s_req_vld}, 32'd0);
    r0 = n_req; d0 = n_deliv; got = 1'b0; cap = '1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b1);
      if (!got && n_req != r0) begin got = 1'b1; cap = last_req_addr; end
    end
    chk_true("stall_release_deliv", (n_deliv - d0) >= 2);
    chk("stall_resume_addr", cap, 32'h8);

    // Redirect with two requests outstanding
    do_reset();
    lat_lo = 4; lat_hi = 4;
    r0 = n_req;
    repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    chk("two_outstanding", n_req - r0, 32'd2);
    cycle(1'b1, 32'h100, 1'b1, 1'b1);
    lat_lo = 1; lat_hi = 1;
    r0 = n_req; got = 1'b0; cap = '1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 32'd0, 1'b1, 1'b1);
      if (!got && n_req != r0) begin got = 1'b1; cap = last_req_addr; end
    end
    chk("redir_first_req", cap, 32'h100);
    chk("redir_first_tag", first_tag, 32'h100);

    // imem not ready: request held stable
    drain(32'h400);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      chk("hold_req_vld", {31'b0, s_req_vld}, 32'd1);
      chk("hold_req_addr", s_req_addr, 32'h400);
    end

    // Alignment, redirect latency and address wrap
    cycle(1'b1, 32'h203, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("redir_next_vld", {31'b0, s_req_vld}, 32'd1);
    chk("redir_aligned", s_req_addr, 32'h200);
    drain(32'hFFFF_FFFC);
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    chk("wrap_addr0", s_req_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    chk("wrap_vld1", {31'b0, s_req_vld}, 32'd1);
    chk("wrap_addr1", s_req_addr, 32'h0);
    repeat (4) cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // Redirect coinciding with a response and a buffered head
    drain(32'h500);
    r0 = n_req;
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    chk("collide_setup_reqs", n_req - r0, 32'd2);
    cycle(1'b1, 32'h600, 1'b0, 1'b0);
    chk("collide_instr_vld", {31'b0, s_instr_vld}, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("collide_fifo_empty", {31'b0, s_instr_vld}, 32'd0);
    repeat (6) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    chk("collide_first_tag", first_tag, 32'h600);

    // Response-to-decode latency
    drain(32'h300);
    r0 = n_req;
    cycle(1'b0, 32'd0, 1'b1, 1'b1);
    chk("lat_req", n_req - r0, 32'd1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("lat_rsp_cycle", {31'b0, s_instr_vld}, {31'b0, BYP});
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    chk("lat_next_cycle", {31'b0, s_instr_vld}, {31'b0, ~BYP});

    // Randomized traffic
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      ld = ($urandom_range(19, 0) == 0);
      t  = $urandom();
      if ($urandom_range(3, 0) == 0) t = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      cycle(ld, t, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);
    end

    lat_lo = 1; lat_hi = 1;
    d0 = n_deliv;
    repeat (20) cycle(1'b0, 32'd0, 1'b1, 1'b1);
    chk_true("liveness", (n_deliv - d0) >= 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
